// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of DEPTH entries with flush; same-cycle push and pop both take effect.
// Head is visible combinationally; a push while full is accepted only if a pop frees a slot that cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2 * XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count_q are ever observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch under a DEPTH credit limit; 2 cycles request-to-instruction at 1-cycle memory,
// stalls requests when decode backs up. FETCH_MISALIGN_CHK_EN: misaligned redirect sets misalign_err and halts.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   kill_q, kill_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] redir_pc;
  logic            redir_bad;
  logic            req_fire;
  logic            inst_fire;
  logic [SW-1:0]   outstanding;
  logic [SW-1:0]   credit_used;
  logic [SW-1:0]   kill_sum;

  logic            q_push, q_pop, q_empty;
  logic [CW-1:0]   q_count;
  logic [XLEN-1:0] q_head;
  logic            f_push, f_empty;
  logic [CW-1:0]   f_count;
  fetch_entry_t    f_head;
  fetch_entry_t    f_push_entry;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_pc  = redirect_pc;
  assign redir_bad = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc  = redirect_pc & ~XLEN'(INST_BYTES - 1);
  assign redir_bad = 1'b0;
`endif

  // Killed-but-not-yet-returned requests still hold a credit, so memory never
  // sees more than DEPTH outstanding. A pop this cycle frees its slot early,
  // which is what lets a 1-cycle memory stream at full rate with DEPTH=2.
  assign outstanding    = SW'(q_count) + SW'(kill_q);
  assign credit_used    = outstanding + SW'(f_count) - SW'(inst_fire);
  assign imem_req_valid = rst && (state_q == ST_RUN) && (credit_used < SW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid   = rst && !f_empty;
  assign inst_fire    = inst_valid && inst_ready;
  assign inst_data    = inst_valid ? f_head.data : '0;
  assign inst_pc      = inst_valid ? f_head.pc : '0;
  assign misalign_err = rst && misalign_q;

  assign f_push_entry = '{pc: q_head, data: imem_rsp_data};

  // A response in the redirect cycle belongs to an older request and is
  // absorbed by the kill count instead of being pushed.
  assign kill_sum = outstanding + SW'(req_fire)
                  - SW'(imem_rsp_valid && (outstanding != '0));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    misalign_d = misalign_q;
    q_push     = 1'b0;
    q_pop      = 1'b0;
    f_push     = 1'b0;
    if (redirect_valid) begin
      pc_d   = redir_pc;
      kill_d = CW'(kill_sum);
      if (redir_bad) begin
        state_d    = ST_HALT;
        misalign_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      if (req_fire) begin
        pc_d   = pc_q + XLEN'(INST_BYTES);
        q_push = 1'b1;
      end
      if (imem_rsp_valid) begin
        if (kill_q != '0) begin
          kill_d = kill_q - CW'(1);
        end else if (!q_empty) begin
          q_pop  = 1'b1;
          f_push = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      kill_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (pc_q),
    .pop       (q_pop),
    .head_data (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (f_push),
    .push_data (f_push_entry),
    .pop       (inst_fire),
    .head_data (f_head),
    .empty     (f_empty),
    .count     (f_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus an expected-PC stream reference.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign_err;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  bit rnd_mode = 0;

  // memory model: accepted addresses returned in order, one per cycle
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due = 0;

  // reference model: the next PC decode should see
  logic [31:0] exp_pc = RESET_PC;
  bit          expect_none = 0;
  bit          hold_vld = 0;
  logic [31:0] hold_addr = '0;

  int          n_acc, n_del, first_acc_cyc, first_del_cyc;
  logic [31:0] first_del_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic clear_counters();
    n_acc = 0; n_del = 0; first_acc_cyc = -1; first_del_cyc = -1;
    first_del_pc = 32'hFFFF_FFFF;
  endtask

  task automatic step();
    int d;
    @(negedge clk);
    if (!rst) begin
      mem_addr_q.delete(); mem_due_q.delete(); last_due = 0;
      exp_pc = RESET_PC; expect_none = 0; hold_vld = 0;
    end else begin
      if (hold_vld && imem_req_valid) begin
        n_chk++;
        if (imem_req_addr !== hold_addr) begin
          n_fail++;
          $display("FAIL addr_hold: got %h, required %h", imem_req_addr, hold_addr);
        end
      end
      hold_vld  = imem_req_valid && !imem_req_ready && !redirect_valid;
      hold_addr = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(d);
        if (n_acc == 0) first_acc_cyc = cyc;
        n_acc++;
      end
      if (inst_valid && inst_ready) begin
        n_chk++;
        if (expect_none) begin
          n_fail++;
          $display("FAIL halt_delivery: got pc %h, required no instruction", inst_pc);
        end else begin
          if (inst_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL inst_pc: got %h, required %h", inst_pc, exp_pc);
          end
          n_chk++;
          if (inst_data !== mem_word(exp_pc)) begin
            n_fail++;
            $display("FAIL inst_data: got %h, required %h", inst_data, mem_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
        end
        if (n_del == 0) begin first_del_pc = inst_pc; first_del_cyc = cyc; end
        n_del++;
      end
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHK_EN
        if (redirect_pc[1:0] != 2'b00) expect_none = 1;
        else begin expect_none = 0; exp_pc = redirect_pc; end
`else
        expect_none = 0;
        exp_pc = {redirect_pc[31:2], 2'b00};
`endif
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    redirect_valid = 1'b0;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr_q.pop_front());
      mem_due_q.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (rnd_mode) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic reset_dut(input int l);
    lat = l; rnd_mode = 0;
    imem_req_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    clear_counters();
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    step(); step();
    #2;
    n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); end
    n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b, required 0", inst_valid); end
    n_chk++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL rst_inst_data: got %h, required 0", inst_data); end
    n_chk++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h, required 0", inst_pc); end
    n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b, required 0", misalign_err); end
    rst = 1'b1;
    clear_counters();
    #1;
    n_chk++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b, required 1", imem_req_valid); end
    n_chk++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL first_req_addr: got %h, required %h", imem_req_addr, RESET_PC); end
    step();
    #2;
    n_chk++; if (imem_req_addr !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL second_req_addr: got %h, required %h", imem_req_addr, RESET_PC + 32'd4); end
  endtask

  task automatic test_stream();
    int base;
    reset_dut(1);
    base = cyc;
    repeat (20) step();
    n_chk++; if (first_acc_cyc !== base) begin n_fail++; $display("FAIL stream_first_acc: got %0d, required %0d", first_acc_cyc, base); end
    n_chk++; if (first_del_cyc !== base + 2) begin n_fail++; $display("FAIL stream_latency: got %0d, required %0d", first_del_cyc, base + 2); end
    n_chk++; if (n_acc !== 20) begin n_fail++; $display("FAIL stream_accepts: got %0d, required 20", n_acc); end
    n_chk++; if (n_del !== 18) begin n_fail++; $display("FAIL stream_throughput: got %0d, required 18", n_del); end
  endtask

  task automatic test_stall();
    reset_dut(1);
    inst_ready = 1'b0;
    repeat (10) step();
    #2;
    n_chk++; if (n_acc !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d, required 2", n_acc); end
    n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid: got %b, required 0", imem_req_valid); end
    n_chk++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin n_fail++; $display("FAIL stall_head: got valid %b pc %h, required 1 %h", inst_valid, inst_pc, RESET_PC); end
    inst_ready = 1'b1;
    repeat (10) step();
    n_chk++; if (n_del !== 10) begin n_fail++; $display("FAIL stall_release: got %0d, required 10", n_del); end
  endtask

  task automatic test_redirect_stale();
    reset_dut(3);
    step(); step();
    #2;
    n_chk++; if (n_acc !== 2 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stale_setup: got acc %0d valid %b, required 2 0", n_acc, imem_req_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    #2;
    n_chk++; if (imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL stale_addr: got %h, required 00000100", imem_req_addr); end
    n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stale_flush: got %b, required 0", inst_valid); end
    clear_counters();
    repeat (20) step();
    n_chk++; if (first_del_pc !== 32'h100) begin n_fail++; $display("FAIL stale_first_pc: got %h, required 00000100", first_del_pc); end
  endtask

  task automatic test_redirect_collide();
    reset_dut(1);
    repeat (6) step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    #2;
    n_chk++; if (!(imem_req_valid && imem_rsp_valid)) begin n_fail++; $display("FAIL collide_setup: got req %b rsp %b, required 1 1", imem_req_valid, imem_rsp_valid); end
    step();
    #2;
    n_chk++; if (imem_req_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL collide_addr: got %h, required fffffff8", imem_req_addr); end
    n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL collide_flush: got %b, required 0", inst_valid); end
    clear_counters();
    repeat (12) step();
    n_chk++; if (first_del_pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL collide_first_pc: got %h, required fffffff8", first_del_pc); end
    n_chk++; if (n_del !== 10) begin n_fail++; $display("FAIL collide_count: got %0d, required 10", n_del); end
  endtask

  task automatic test_misalign();
    reset_dut(1);
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    #2;
`ifdef FETCH_MISALIGN_CHK_EN
    n_chk++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_flag: got %b, required 1", misalign_err); end
    clear_counters();
    repeat (10) step();
    #2;
    n_chk++; if (n_acc !== 0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_requests: got acc %0d valid %b, required 0 0", n_acc, imem_req_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    #2;
    n_chk++; if (imem_req_addr !== 32'h200 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL resume_addr: got %h valid %b, required 00000200 1", imem_req_addr, imem_req_valid); end
    clear_counters();
    repeat (10) step();
    n_chk++; if (first_del_pc !== 32'h200) begin n_fail++; $display("FAIL resume_first_pc: got %h, required 00000200", first_del_pc); end
    n_chk++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b, required 1", misalign_err); end
`else
    n_chk++; if (imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL align_addr: got %h, required 00000100", imem_req_addr); end
    n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_tied: got %b, required 0", misalign_err); end
    clear_counters();
    repeat (10) step();
    n_chk++; if (first_del_pc !== 32'h100) begin n_fail++; $display("FAIL align_first_pc: got %h, required 00000100", first_del_pc); end
`endif
  endtask

  task automatic test_reset_mid();
    reset_dut(2);
    rnd_mode = 1;
    repeat (30) step();
    rst = 1'b0;
    #2;
    n_chk++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valids: got req %b inst %b, required 0 0", imem_req_valid, inst_valid); end
    n_chk++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL mid_rst_inst: got data %h pc %h, required 0 0", inst_data, inst_pc); end
    n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_misalign: got %b, required 0", misalign_err); end
    step();
    rst = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0BAD;
    clear_counters();
    #2;
    n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL mid_refetch: got valid %b addr %h, required 1 %h", imem_req_valid, imem_req_addr, RESET_PC); end
    repeat (40) step();
    n_chk++; if (first_del_pc !== RESET_PC) begin n_fail++; $display("FAIL mid_first_pc: got %h, required %h", first_del_pc, RESET_PC); end
  endtask

  task automatic test_random();
    reset_dut(1);
    rnd_mode = 1;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
      end
      step();
    end
    rnd_mode = 0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (30) step();
    n_chk++; if (n_del <= 40) begin n_fail++; $display("FAIL random_progress: got %0d deliveries, required more than 40", n_del); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_collide();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, default 2, maximum instructions in flight plus buffered (2..4).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address.
REQ-007 imem_req_valid  output  1  fetch request to instruction memory.
REQ-008 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_req_addr  output  32  fetch address; held stable while valid && !ready.
REQ-010 imem_rsp_valid  input  1  response beat; responses return in order, at least 1 cycle after acceptance.
REQ-011 imem_rsp_data  input  32  instruction word.
REQ-012 inst_valid  output  1  instruction available to decode.
REQ-013 inst_ready  input  1  decode consumes the instruction this cycle.
REQ-014 inst_data  output  32  instruction word.
REQ-015 inst_pc  output  32  address of inst_data.
REQ-016 misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-017 The block SHALL hold a fetch PC; an accepted request (valid && ready) SHALL advance it by 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-018 imem_req_valid SHALL be asserted only when in_flight + fifo_count < DEPTH and the FSM is in RUN.
REQ-019 Each accepted address SHALL be pushed into an in-flight PC queue; each response SHALL pop it and push {pc, data} into an output FIFO of DEPTH entries.
REQ-020 Output FIFO head SHALL drive inst_valid/inst_data/inst_pc; pop on inst_valid && inst_ready; push and pop in the same cycle SHALL both occur.
REQ-021 Credit rule (REQ-018) SHALL guarantee no FIFO overflow; a response SHALL never be dropped except by REQ-022.
REQ-022 On redirect_valid: PC <= redirect_pc, output FIFO flushed, inst_valid low next cycle, and a kill counter loaded with all outstanding requests (including one accepted in the same cycle); responses SHALL be discarded while kill counter > 0, decrementing per response.
REQ-023 A response arriving in the redirect cycle SHALL be discarded and SHALL count against the kill counter.
REQ-024 Redirect SHALL take priority over PC increment in the same cycle; imem_req_addr SHALL equal redirect_pc in the following cycle.
REQ-025 FSM states: RUN (fetching) and HALT (no requests); RUN->HALT per REQ-030; HALT->RUN on aligned redirect.
REQ-026 Latency: 1-cycle memory latency with inst_ready=1 SHALL sustain one instruction per cycle; first inst_valid SHALL appear 2 cycles after the first accepted request.

Reset
REQ-027 While rst=0: PC=RESET_PC, FSM=RUN, FIFO and in-flight queue empty, kill counter 0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0.
REQ-028 In the first cycle after rst rises, imem_req_valid=1 with imem_req_addr=RESET_PC.
REQ-029 Reset mid-operation SHALL abandon in-flight requests; responses arriving after reset with no queue entry SHALL be ignored.

Configuration
REQ-030 With FETCH_MISALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=0 sets misalign_err=1 (sticky until reset), enters HALT, and issues no request; without it: redirect_pc[1:0] forced to 0, misalign_err tied 0, HALT unreachable.

Structure
REQ-031 Package fetch_pkg SHALL hold XLEN=32, INST_BYTES=4, the FSM state typedef and the fifo entry typedef {pc, data}.
REQ-032 One sub-module fetch_fifo (parameterised DEPTH, width 64, with flush) SHALL implement the output FIFO; the in-flight PC queue reuses it.

Verification
REQ-033 Reset, imem ready=1, 1-cycle latency, data=addr^32'hA5A5_A5A5 -> inst_pc 0,4,8,... one per cycle, data matches.
REQ-034 inst_ready=0 for 10 cycles -> imem_req_valid falls after DEPTH=2 requests; releasing yields pcs 0,4,8 with none lost or duplicated.
REQ-035 Redirect to 32'h100 with 2 requests in flight (3-cycle latency) -> both stale responses dropped; next inst_pc=32'h100.
REQ-036 Redirect in the same cycle as a response and an accepted request -> both discarded; first inst_pc = redirect_pc.
REQ-037 Redirect to 32'h102: with macro -> misalign_err=1, no requests until redirect to 32'h200; without -> fetch at 32'h100.
REQ-038 rst low for 1 cycle mid-stream -> all outputs at reset values; refetch starts at RESET_PC.
